mem_access_seq: RTL and testbench
=================================

# mem_access_seq

Multicycle phase sequencer and Avalon-MM master for the CPU core. Generates the `state` phase code (FETCH/EXEC/WB/HALTED) consumed by the waitrequest qualifier and the datapath. Issues instruction fetches and load/store bus cycles, holding them across `waitrequest`. Captures the fetched instruction and the extracted, extended load data.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC0_0000, value loaded into internal fetch PC mirror check (informational; PC itself is external)

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pc`  in  32  current program counter from datapath
- `opcode`  in  6  opcode field of latched instruction (instr[31:26])
- `mem_addr`  in  32  effective address from ALU, valid in EXEC
- `store_data`  in  32  rt register value, valid in EXEC
- `halt_req`  in  1  datapath signals jump to address 0 retired; sampled in WB
- `waitrequest`  in  1  Avalon slave stall
- `readdata`  in  32  Avalon read data, valid when read=1 and waitrequest=0
- `address`  out  32  Avalon address, always word aligned
- `read`  out  1  Avalon read strobe
- `write`  out  1  Avalon write strobe
- `byteenable`  out  4  Avalon byte lanes, little-endian
- `writedata`  out  32  lane-replicated store data
- `state`  out  2  phase: 0 FETCH, 1 EXEC, 2 WB, 3 HALTED
- `instr`  out  32  registered fetched instruction
- `load_data`  out  32  registered extended load result
- `addr_err`  out  1  one-cycle pulse on misaligned LH/LHU/LW/SH/SW
- `active`  out  1  high in every state except HALTED

## Operation
- FETCH: `read`=1, `address`={pc[31:2],2'b00}, `byteenable`=4'b1111. Edge with waitrequest=0: `instr`<=readdata, go EXEC. Else stay, outputs held stable.
- EXEC, opcode[5]=0: no bus access, go WB next edge.
- EXEC loads (LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, LWL 100010, LWR 100110): `read`=1, `address`={mem_addr[31:2],2'b00}. Edge with waitrequest=0: `load_data`<=extracted value, go WB.
- EXEC stores (SB 101000, SH 101001, SW 101011): `write`=1; SB byteenable=1<<a, writedata={4{sd[7:0]}}; SH byteenable=a[1]?1100:0011, writedata={2{sd[15:0]}}; SW 1111, sd. a=mem_addr[1:0]. Edge with waitrequest=0: go WB.
- Other opcode[5]=1 codes (SWL/SWR/cache etc.): no bus access, go WB.
- Extraction: LB/LBU select byte a, sign/zero extend; LH/LHU select half a[1], sign/zero extend; LW/LWL/LWR raw word (merge done downstream).
- Alignment: LH/LHU/SH with a[0]=1, LW/SW with a!=0 -> no strobe asserted, `addr_err` pulses in that EXEC cycle, go WB; `load_data` unchanged.
- WB: no bus strobes. Next edge: halt_req=1 -> HALTED, else FETCH.
- HALTED: terminal until reset; strobes 0, `active`=0.

## Timing
- Reset values: state=FETCH, read=0 during reset then 1 combinationally in FETCH, write=0, instr=0, load_data=0, addr_err=0, active=1.
- Bus outputs combinational from state, opcode, pc, mem_addr; must not change while waitrequest=1 (inputs held by datapath).
- Minimum instruction: 3 cycles (FETCH, EXEC, WB) with zero waitrequest; each waitrequest cycle adds one.
- `read` and `write` never both 1; never asserted in WB/HALTED.
- Reset mid-transfer: strobes drop asynchronously; no capture.
- waitrequest ignored when no strobe asserted.

## Structure
- Package `mips_pkg`: state enum (FETCH/EXEC/WB/HALTED, 2 bits, encodings fixed as above), load/store opcode localparams.
- Sub-module `load_extract`: combinational lane select + extension (opcode, a, readdata -> 32-bit result).

## Test plan
- Reset, pc=32'hBFC0_0000, waitrequest=0, readdata=32'h8C01_0004 -> address=BFC0_0000, read=1, instr=8C01_0004 after 1 edge, state=1.
- LB, mem_addr=0x1003, readdata=32'h80FF_FFFF, waitrequest high 2 cycles -> byteenable 1111, read held 3 cycles, load_data=FFFF_FF80; LBU -> 0000_0080.
- SH, mem_addr=0x2002, store_data=0x1234_ABCD -> write=1, byteenable=1100, writedata=ABCD_ABCD, then WB.
- LW, mem_addr=0x2001 -> no read, addr_err pulse one cycle, load_data unchanged, state 1->2->0.
- halt_req=1 in WB -> state=3, active=0, read/write stay 0 for 10 cycles.
- rst_n low during waitrequest-stalled FETCH -> read drops immediately, state=0, instr=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the multicycle core's memory sequencer: phase encoding,
// load/store opcodes and small opcode classification helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_WB     = 2'd2,
    ST_HALTED = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_LOAD,
    ACC_STORE
  } access_e;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  function automatic access_e access_kind(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return ACC_LOAD;
      OP_SB, OP_SH, OP_SW:                                 return ACC_STORE;
      default:                                             return ACC_NONE;
    endcase
  endfunction

  // LWL/LWR and byte accesses are legal at any address.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero
// extends it; word-sized loads pass the raw word for the downstream merge.
module load_extract
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  a,
  input  logic [31:0] readdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = readdata[7:0];
    case (a)
      2'd0: byte_sel = readdata[7:0];
      2'd1: byte_sel = readdata[15:8];
      2'd2: byte_sel = readdata[23:16];
      2'd3: byte_sel = readdata[31:24];
      default: byte_sel = readdata[7:0];
    endcase
    half_sel = a[1] ? readdata[31:16] : readdata[15:0];

    case (opcode)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0, half_sel};
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Phase sequencer and Avalon-MM master: fetches, then issues the load/store
// of the latched instruction, holding the bus cycle across waitrequest.
//
// state  | meaning
// FETCH  | read instruction at pc, capture into instr
// EXEC   | load/store bus cycle for opcode, or pass through
// WB     | datapath writeback, no bus activity; halt_req sampled here
// HALTED | terminal until reset, bus idle, active=0
module mem_access_seq
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [5:0]  opcode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic        halt_req,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [1:0]  state,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        active
);

  phase_e      state_q, state_d;
  access_e     kind;
  logic        misal;
  logic        rd_en, wr_en;
  logic [1:0]  a;
  logic [31:0] ext_data;
  logic [31:0] instr_q, load_q;
  logic        unused_pc_lsb;

  assign a             = mem_addr[1:0];
  assign kind          = access_kind(opcode);
  assign misal         = misaligned(opcode, a);
  assign unused_pc_lsb = ^pc[1:0];

  load_extract u_load_extract (
    .opcode   (opcode),
    .a        (a),
    .readdata (readdata),
    .result   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
      load_q  <= 32'h0;
    end else begin
      if (state_q == ST_FETCH && !waitrequest)
        instr_q <= readdata;
      if (state_q == ST_EXEC && kind == ACC_LOAD && !misal && !waitrequest)
        load_q <= ext_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = {pc[31:2], 2'b00};
    byteenable = 4'b1111;
    writedata  = store_data;
    addr_err   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        rd_en = 1'b1;
        if (!waitrequest) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        address = {mem_addr[31:2], 2'b00};
        if (misal) begin
          addr_err = 1'b1;
          state_d  = ST_WB;
        end else begin
          case (kind)
            ACC_LOAD: begin
              rd_en = 1'b1;
              if (!waitrequest) state_d = ST_WB;
            end
            ACC_STORE: begin
              wr_en = 1'b1;
              case (opcode)
                OP_SB: begin
                  byteenable = 4'b0001 << a;
                  writedata  = {4{store_data[7:0]}};
                end
                OP_SH: begin
                  byteenable = a[1] ? 4'b1100 : 4'b0011;
                  writedata  = {2{store_data[15:0]}};
                end
                default: begin
                  byteenable = 4'b1111;
                  writedata  = store_data;
                end
              endcase
              if (!waitrequest) state_d = ST_WB;
            end
            default: state_d = ST_WB;
          endcase
        end
      end
      ST_WB: state_d = halt_req ? ST_HALTED : ST_FETCH;
      ST_HALTED: address = {RESET_VECTOR[31:2], 2'b00};
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes are gated by reset so a stalled transfer is abandoned at once.
  assign read      = rd_en & rst_n;
  assign write     = wr_en & rst_n;
  assign state     = state_q;
  assign instr     = instr_q;
  assign load_data = load_q;
  assign active    = (state_q != ST_HALTED);

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized bench for mem_access_seq against a behavioural instruction-level
// model of the fetch/load/store bus cycles and load extraction.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, mem_addr, store_data, readdata;
  logic [5:0]  opcode;
  logic        halt_req, waitrequest;
  logic [31:0] address, writedata, instr, load_data;
  logic        read, write, addr_err, active;
  logic [3:0]  byteenable;
  logic [1:0]  state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_load  = 32'h0;

  logic [5:0] op_pool [16] = '{
    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
    6'b100110, 6'b101000, 6'b101001, 6'b101011, 6'b101010, 6'b101110,
    6'b101111, 6'b000000, 6'b001001, 6'b110000
  };

  mem_access_seq dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .opcode(opcode), .mem_addr(mem_addr),
    .store_data(store_data), .halt_req(halt_req), .waitrequest(waitrequest),
    .readdata(readdata), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .state(state),
    .instr(instr), .load_data(load_data), .addr_err(addr_err), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 = no bus access, 1 = load, 2 = store
  function automatic int m_kind(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110: return 1;
      6'b101000, 6'b101001, 6'b101011: return 2;
      default:                         return 0;
    endcase
  endfunction

  function automatic int m_align(input logic [5:0] op);
    case (op)
      6'b100001, 6'b100101, 6'b101001: return 2;
      6'b100011, 6'b101011:            return 4;
      default:                         return 1;
    endcase
  endfunction

  function automatic logic [31:0] m_extract(input logic [5:0] op, input int ofs, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * ofs)) & 32'hFF;
    h = (rd >> (16 * (ofs / 2))) & 32'hFFFF;
    case (op)
      6'b100000: return (b >= 32'h80) ? b - 32'h100 : b;
      6'b100100: return b;
      6'b100001: return (h >= 32'h8000) ? h - 32'h10000 : h;
      6'b100101: return h;
      default:   return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input int ofs);
    case (op)
      6'b101000: return 4'(1 << ofs);
      6'b101001: return (ofs >= 2) ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] sd);
    case (op)
      6'b101000: return (sd & 32'hFF) * 32'h0101_0101;
      6'b101001: return (sd & 32'hFFFF) * 32'h0001_0001;
      default:   return sd;
    endcase
  endfunction

  // One full instruction; entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] pc_v, input logic [31:0] ins, input int fw,
                           input logic [31:0] ma, input logic [31:0] sd,
                           input logic [31:0] rdv, input int ew, input logic halt);
    int  kind, ofs;
    logic mis;
    pc = pc_v;
    for (int k = 0; k <= fw; k++) begin
      waitrequest = (k < fw);
      readdata    = (k < fw) ? $urandom : ins;
      #1;
      chk("fetch_state", 32'(state), 32'd0);
      chk("fetch_read", 32'(read), 32'd1);
      chk("fetch_write", 32'(write), 32'd0);
      chk("fetch_addr", address, pc_v & 32'hFFFF_FFFC);
      chk("fetch_be", 32'(byteenable), 32'hF);
      @(posedge clk); #1;
    end
    chk("instr", instr, ins);
    chk("exec_state", 32'(state), 32'd1);

    opcode = ins[31:26]; mem_addr = ma; store_data = sd;
    kind = m_kind(opcode);
    ofs  = int'(ma % 4);
    mis  = (ma % m_align(opcode)) != 0;
    if (mis || kind == 0) begin
      waitrequest = 1'($urandom);
      readdata    = $urandom;
      #1;
      chk("exec_read", 32'(read), 32'd0);
      chk("exec_write", 32'(write), 32'd0);
      chk("addr_err", 32'(addr_err), 32'(mis));
      @(posedge clk); #1;
    end else begin
      for (int k = 0; k <= ew; k++) begin
        waitrequest = (k < ew);
        readdata    = (k < ew) ? $urandom : rdv;
        #1;
        chk("exec_hold_state", 32'(state), 32'd1);
        chk("exec_read", 32'(read), 32'(kind == 1));
        chk("exec_write", 32'(write), 32'(kind == 2));
        chk("exec_addr", address, ma & 32'hFFFF_FFFC);
        chk("addr_err", 32'(addr_err), 32'd0);
        if (kind == 2) begin
          chk("store_be", 32'(byteenable), 32'(m_be(opcode, ofs)));
          chk("store_wd", writedata, m_wd(opcode, sd));
        end else begin
          chk("load_be", 32'(byteenable), 32'hF);
        end
        @(posedge clk); #1;
      end
      if (kind == 1) m_load = m_extract(opcode, ofs, rdv);
    end

    chk("wb_state", 32'(state), 32'd2);
    chk("load_data", load_data, m_load);
    halt_req    = halt;
    waitrequest = 1'($urandom);
    #1;
    chk("wb_read", 32'(read), 32'd0);
    chk("wb_write", 32'(write), 32'd0);
    chk("wb_addr_err", 32'(addr_err), 32'd0);
    @(posedge clk); #1;
    halt_req = 1'b0;
    chk("next_state", 32'(state), halt ? 32'd3 : 32'd0);
  endtask

  initial begin
    logic [31:0] ma;
    logic [5:0]  op;
    rst_n = 1'b0; pc = 32'h0; opcode = 6'h0; mem_addr = 32'h0; store_data = 32'h0;
    halt_req = 1'b0; waitrequest = 1'b0; readdata = 32'h0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_active", 32'(active), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(32'hBFC0_0000, 32'h8C01_0004, 0, 32'h1000, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    run_instr(32'hBFC0_0004, {6'b100000, 26'h0}, 1, 32'h1003, 32'h0, 32'h80FF_FFFF, 2, 1'b0);
    chk("dir_lb", load_data, 32'hFFFF_FF80);
    run_instr(32'hBFC0_0008, {6'b100100, 26'h0}, 0, 32'h1003, 32'h0, 32'h80FF_FFFF, 2, 1'b0);
    chk("dir_lbu", load_data, 32'h0000_0080);
    run_instr(32'hBFC0_000C, {6'b101001, 26'h0}, 0, 32'h2002, 32'h1234_ABCD, 32'h0, 0, 1'b0);
    run_instr(32'hBFC0_0010, {6'b100011, 26'h0}, 0, 32'h2001, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    chk("dir_lw_misal", load_data, 32'h0000_0080);

    for (int i = 0; i < 300; i++) begin
      op = op_pool[$urandom_range(0, 15)];
      ma = $urandom;
      if ($urandom_range(0, 1) == 1) ma[1:0] = 2'b00;
      run_instr($urandom, {op, 26'($urandom)}, $urandom_range(0, 3), ma, $urandom,
                $urandom, $urandom_range(0, 3), 1'b0);
    end

    run_instr(32'h0000_0000, {6'b101011, 26'h0}, 0, 32'h40, 32'h1111_2222, 32'h0, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      waitrequest = 1'($urandom);
      readdata    = $urandom;
      #1;
      chk("halt_state", 32'(state), 32'd3);
      chk("halt_active", 32'(active), 32'd0);
      chk("halt_read", 32'(read), 32'd0);
      chk("halt_write", 32'(write), 32'd0);
      @(posedge clk); #1;
    end

    rst_n = 1'b0;
    #1;
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_active", 32'(active), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; pc = 32'h0000_1000; waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("stall_read", 32'(read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_read", 32'(read), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_load", load_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
